// File: rtl/decode_pkg.sv
// decode_pkg -- shared types and constants for the decode queue.
//   insn_class_e : instruction format class carried with every queue entry
//   OP_*         : RV32 major opcodes (insn[6:0]) recognised by the classifier
//   decq_entry_t : one stored queue entry (insn, pc, immediate, class)
//   sext12       : sign-extend a 12-bit immediate field to DECQ_XLEN
package decode_pkg;

  // The instruction encodings are RV32, so entry fields are fixed at 32 bits.
  localparam int DECQ_XLEN = 32;

  typedef enum logic [2:0] {
    CLASS_R       = 3'd0,
    CLASS_I       = 3'd1,
    CLASS_S       = 3'd2,
    CLASS_B       = 3'd3,
    CLASS_U       = 3'd4,
    CLASS_J       = 3'd5,
    CLASS_ILLEGAL = 3'd7
  } insn_class_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [DECQ_XLEN-1:0] insn;
    logic [DECQ_XLEN-1:0] pc;
    logic [DECQ_XLEN-1:0] imm;
    insn_class_e          insn_class;
  } decq_entry_t;

  function automatic logic [DECQ_XLEN-1:0] sext12(input logic [11:0] v);
    return {{(DECQ_XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/decq_imm_decode.sv
// decq_imm_decode -- purely combinational instruction classifier.
//   insn       : raw 32-bit instruction
//   insn_class : format class (R/I/S/B/U/J, 7 = illegal opcode)
//   imm        : sign-extended immediate for that format (0 for R and illegal)
module decq_imm_decode
  import decode_pkg::*;
(
  input  logic [DECQ_XLEN-1:0] insn,
  output logic [2:0]           insn_class,
  output logic [DECQ_XLEN-1:0] imm
);

  always_comb begin
    insn_class = CLASS_ILLEGAL;
    imm        = '0;
    case (insn[6:0])
      OP_REG: begin
        insn_class = CLASS_R;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        insn_class = CLASS_I;
        imm        = sext12(insn[31:20]);
      end
      OP_STORE: begin
        insn_class = CLASS_S;
        imm        = sext12({insn[31:25], insn[11:7]});
      end
      OP_BRANCH: begin
        // 13-bit byte offset, bit 0 implicitly zero
        insn_class = CLASS_B;
        imm        = {{(DECQ_XLEN-12){insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        insn_class = CLASS_U;
        imm        = {insn[31:12], 12'b0};
      end
      OP_JAL: begin
        // 21-bit byte offset, bit 0 implicitly zero
        insn_class = CLASS_J;
        imm        = {{(DECQ_XLEN-20){insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      default: begin
        insn_class = CLASS_ILLEGAL;
        imm        = '0;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue -- instruction buffer between fetch and rename.
// Each (insn, pc) accepted from fetch is classified and its immediate built
// on the way in; the decoded entry is held in a circular FIFO whose head is
// presented to rename. A flush empties the queue at the next edge.
//
// Ports:
//   clk, rst_n               : clock (rising edge), asynchronous active-low reset
//   flush                    : discard every entry; overrides both handshakes
//   in_valid/in_ready        : fetch handshake, in_insn / in_pc payload
//   out_valid/out_ready      : rename handshake on the head entry
//   out_insn/out_pc/out_imm  : head entry fields (0 when empty)
//   out_class                : head entry format class (0 when empty)
//   count                    : number of occupied entries
//
// Build option: define DECODE_QUEUE_BYPASS_EN to let an instruction offered
// to an empty queue pass straight to rename in the same cycle when rename is
// ready; it is then never written to storage.
//
// XLEN must stay 32: the opcode/immediate layout is the RV32 one.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_insn,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_insn,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_class,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full;
  logic          enq, deq, bypass;

  logic [2:0]      dec_class;
  logic [XLEN-1:0] dec_imm;
  decq_entry_t     wr_entry;
  decq_entry_t     head_entry;
  decq_entry_t     mem [DEPTH];

  decq_imm_decode u_imm_decode (
    .insn       (in_insn),
    .insn_class (dec_class),
    .imm        (dec_imm)
  );

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign count  = wr_ptr_reg - rd_ptr_reg;

  // Acceptance never looks at out_ready: a full queue refuses even when the
  // head is leaving in the same cycle.
  assign in_ready = !full && !flush;

`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass = empty && !flush && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction goes straight to rename and never touches storage.
  assign enq = in_valid && in_ready && !bypass;
  assign deq = !empty && out_ready;

  assign wr_entry.insn       = in_insn;
  assign wr_entry.pc         = in_pc;
  assign wr_entry.imm        = dec_imm;
  assign wr_entry.insn_class = insn_class_e'(dec_class);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (enq) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (deq) rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Entry storage needs no reset: nothing is visible unless the pointers say
  // the slot is occupied.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_idx] <= wr_entry;
  end

  assign head_entry = mem[rd_idx];

  always_comb begin
    out_valid = !empty;
    out_insn  = '0;
    out_pc    = '0;
    out_imm   = '0;
    out_class = '0;
    if (!empty) begin
      out_insn  = head_entry.insn;
      out_pc    = head_entry.pc;
      out_imm   = head_entry.imm;
      out_class = head_entry.insn_class;
    end
`ifdef DECODE_QUEUE_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_insn  = in_insn;
      out_pc    = in_pc;
      out_imm   = dec_imm;
      out_class = dec_class;
    end
`endif
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue -- scoreboard bench for decode_queue.
// The stimulus process drives inputs just after each rising edge; a monitor
// on the falling edge pushes the expected decode of every accepted
// instruction and pops/compares on every completed rename handshake.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef DECODE_QUEUE_BYPASS_EN
  localparam int STREAM_COUNT = 0;
`else
  localparam int STREAM_COUNT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   in_insn = '0;
  logic [XLEN-1:0]   in_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_insn;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_class;
  logic [$clog2(DEPTH):0] count;

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_insn   (in_insn),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_pc    (out_pc),
    .out_imm   (out_imm),
    .out_class (out_class),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  cls;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference decode: field values assembled by weighted sums, signed
  // offsets folded by subtracting the field's range.
  function automatic exp_t model(input logic [31:0] insn, input logic [31:0] pc);
    exp_t e;
    longint v;
    e.insn = insn;
    e.pc   = pc;
    v      = 0;
    case (insn[6:0])
      7'h33: e.cls = 3'd0;
      7'h13, 7'h03, 7'h67: begin
        e.cls = 3'd1;
        v = longint'(insn[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        e.cls = 3'd2;
        v = longint'(insn[31:25]) * 32 + longint'(insn[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        e.cls = 3'd3;
        v = longint'(insn[31]) * 4096 + longint'(insn[7]) * 2048
          + longint'(insn[30:25]) * 32 + longint'(insn[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        e.cls = 3'd4;
        v = longint'(insn[31:12]) * 4096;
      end
      7'h6F: begin
        e.cls = 3'd5;
        v = longint'(insn[31]) * 1048576 + longint'(insn[19:12]) * 4096
          + longint'(insn[20]) * 2048 + longint'(insn[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: e.cls = 3'd7;
    endcase
    e.imm = v[31:0];
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic exp_valid;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_count", 32'(count), 32'd0);
    end else begin
      chk("count", 32'(count), 32'(sb.size()));
      chk("in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < DEPTH) && !flush});
      exp_valid = (sb.size() != 0);
`ifdef DECODE_QUEUE_BYPASS_EN
      if (sb.size() == 0 && in_valid && out_ready && !flush) exp_valid = 1'b1;
`endif
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (flush) begin
        sb.delete();
      end else begin
        if (in_valid && in_ready) sb.push_back(model(in_insn, in_pc));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL deq_unexpected: got insn 0x%08h, expected no output", out_insn);
          end else begin
            e = sb.pop_front();
            $display("[TB] deq insn=%08h pc=%08h imm=%08h class=%0d", out_insn, out_pc, out_imm, out_class);
            chk("deq_insn", out_insn, e.insn);
            chk("deq_pc", out_pc, e.pc);
            chk("deq_imm", out_imm, e.imm);
            chk("deq_class", {29'b0, out_class}, {29'b0, e.cls});
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    in_valid  = v;
    in_insn   = insn;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 16) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset_out_insn", out_insn, 32'h0);
    chk("reset_out_class", {29'b0, out_class}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

    // addi x1,x0,-1 with rename ready
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
`ifndef DECODE_QUEUE_BYPASS_EN
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_class", {29'b0, out_class}, 32'd1);
    chk("addi_pc", out_pc, 32'h100);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("addi_count_back", 32'(count), 32'd0);

    // lui then jal, held, then drained in order
    step(1'b1, 32'h12345037, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'hFFDFF06F, 32'h108, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_class", {29'b0, out_class}, 32'd4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("jal_imm", out_imm, 32'hFFFFFFFC);
    chk("jal_class", {29'b0, out_class}, 32'd5);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("lui_jal_count", 32'(count), 32'd0);

    // Fill to full, refuse a fifth offer, then drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_insn(), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b1, 32'h00000033, 32'h210, 1'b1, 1'b0);
    chk("full_refuse_count", 32'(count), 32'(DEPTH - 1));
    chk("full_ready_rises", {31'b0, in_ready}, 32'd1);
    drain();

    // Continuous enqueue + dequeue, pointers wrap
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rand_insn(), 32'h300 + 32'(i * 4), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 32'(STREAM_COUNT));
    end
    drain();

    // Flush with a simultaneous offer and consume
    for (int i = 0; i < 3; i++) step(1'b1, rand_insn(), 32'h400 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 32'h40C, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_dropped", 32'(count), 32'd0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_insn(), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0));
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drain();

    // Illegal opcode, then asynchronous reset mid-cycle
    step(1'b1, 32'h0000007F, 32'h500, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("illegal_class", {29'b0, out_class}, 32'd7);
    chk("illegal_imm", out_imm, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_out_class", {29'b0, out_class}, 32'd0);
    chk("async_out_insn", out_insn, 32'h0);
    chk("async_count", 32'(count), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("after_reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("after_reset_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
